// File: rtl/cos_issue_sequencer.sv
// cos_issue_sequencer
// Buffers (x, y) operand pairs in a small FIFO and issues them one at a time
// to the ROM-based cosine core with a single-cycle start pulse, then captures
// the core result into a valid/ready output slot.
// Optional feature: define COS_SEQ_TIMEOUT_EN to bound the wait for the core
// to drop Ready after start; on expiry the request is dropped and err is set.
module cos_issue_sequencer #(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_x,
  input  logic [W-1:0]             in_y,
  output logic                     core_start,
  input  logic                     core_ready,
  output logic [W-1:0]             core_x,
  output logic [W-1:0]             core_y,
  input  logic [W-1:0]             core_w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_w,
  output logic                     busy,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  // Reject configurations the pointer arithmetic cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("cos_issue_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_mem_x [DEPTH];
  logic [W-1:0]    r_mem_y [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_fill;
  logic            r_start;
  logic [W-1:0]    r_core_x;
  logic [W-1:0]    r_core_y;
  logic            r_out_valid;
  logic [W-1:0]    r_out_w;

  logic            w_in_ready;
  logic            w_push;
  logic            w_pop;

  // FIFO is full only at exactly DEPTH entries; no pass-through on full.
  assign w_in_ready = (r_fill != (AW + 1)'(DEPTH));
  assign w_push     = in_valid && w_in_ready;
  // Issue only from IDLE, with something queued and the result slot free
  // (or being freed this very cycle).
  assign w_pop      = (r_state == IDLE) && (r_fill != '0) && (!r_out_valid || out_ready);

  // Operand storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wr_ptr] <= in_x;
      r_mem_y[r_wr_ptr] <= in_y;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + (AW + 1)'(1);
        2'b01:   r_fill <= r_fill - (AW + 1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

`ifdef COS_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Issue FSM with timeout: start pulse, wait for core to go busy, capture result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_start     <= 1'b0;
      r_core_x    <= '0;
      r_core_y    <= '0;
      r_out_valid <= 1'b0;
      r_out_w     <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_core_x <= r_mem_x[r_rd_ptr];
            r_core_y <= r_mem_y[r_rd_ptr];
            r_start  <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!core_ready) begin
            r_state <= WAIT_DONE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            // Core never acknowledged: drop the request, no result produced.
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (core_ready) begin
            // A capture overrides a same-cycle accept, so out_valid stays high.
            r_out_w     <= core_w;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign err = r_err;
`else
  // Issue FSM: start pulse, wait for core to go busy, capture result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_start     <= 1'b0;
      r_core_x    <= '0;
      r_core_y    <= '0;
      r_out_valid <= 1'b0;
      r_out_w     <= '0;
    end else begin
      r_start <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_core_x <= r_mem_x[r_rd_ptr];
            r_core_y <= r_mem_y[r_rd_ptr];
            r_start  <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!core_ready) r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (core_ready) begin
            // A capture overrides a same-cycle accept, so out_valid stays high.
            r_out_w     <= core_w;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign err = 1'b0;
`endif

  assign in_ready   = w_in_ready;
  assign core_start = r_start;
  assign core_x     = r_core_x;
  assign core_y     = r_core_y;
  assign out_valid  = r_out_valid;
  assign out_w      = r_out_w;
  assign busy       = (r_state != IDLE);
  assign fill       = r_fill;

endmodule

// File: tb/tb_cos_issue_sequencer.sv
// Bench for cos_issue_sequencer: core stub (w = x + y), queue-based reference
// model, per-cycle compare process, directed scenarios plus random traffic.
module tb_cos_issue_sequencer;
  localparam int W       = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_x, in_y;
  logic          core_start;
  logic          core_ready;
  logic [W-1:0]  core_x, core_y, core_w;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_w;
  logic          busy;
  logic          err;
  logic [$clog2(DEPTH):0] fill;

  cos_issue_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .core_start(core_start), .core_ready(core_ready),
    .core_x(core_x), .core_y(core_y), .core_w(core_w), .out_valid(out_valid),
    .out_ready(out_ready), .out_w(out_w), .busy(busy), .err(err), .fill(fill)
  );

  always #5 clk = ~clk;

  // Core stub: Ready low the cycle after start, high again 6 cycles later.
  logic stub_rdy;
  logic stub_hold;
  int   stub_cnt;
  assign core_ready = stub_rdy;
  assign core_w     = core_x + core_y;

  always @(posedge clk) begin
    if (rst) begin
      stub_rdy <= 1'b1;
      stub_cnt <= 0;
    end else if (stub_hold) begin
      stub_rdy <= 1'b1;
      stub_cnt <= 0;
    end else if (core_start) begin
      stub_rdy <= 1'b0;
      stub_cnt <= 6;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_rdy <= 1'b1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending pairs, in-flight expected results, accepted results.
  typedef struct packed { logic [W-1:0] x; logic [W-1:0] y; } pair_t;
  pair_t        pq[$];
  logic [W-1:0] rq[$];
  logic [W-1:0] got[$];
  int           m_fill  = 0;
  int           n_start = 0;
  bit           chk_en  = 1'b0;
  bit           saw_full = 1'b0;

  logic         prev_rst = 1'b1;
  logic         prev_start, prev_busy, prev_slot_free, prev_hold, prev_err;
  logic [W-1:0] prev_cx, prev_cy, prev_outw;

  // Per-cycle compare of DUT against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      pair_t p;
      if (prev_rst) begin
        check("rst_in_ready",   in_ready,   1);
        check("rst_core_start", core_start, 0);
        check("rst_core_x",     core_x,     0);
        check("rst_core_y",     core_y,     0);
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_w",      out_w,      0);
        check("rst_busy",       busy,       0);
        check("rst_err",        err,        0);
        check("rst_fill",       fill,       0);
      end else begin
        if (!core_start) begin
          check("core_x_stable", core_x, prev_cx);
          check("core_y_stable", core_y, prev_cy);
        end
        if (prev_hold) begin
          check("out_w_stalled", out_w, prev_outw);
          check("out_valid_stalled", out_valid, 1);
        end
`ifdef COS_SEQ_TIMEOUT_EN
        if (prev_err) check("err_sticky", err, 1);
`endif
      end
`ifndef COS_SEQ_TIMEOUT_EN
      check("err_tied_low", err, 0);
`endif
      if (core_start) begin
        n_start++;
        m_fill--;
        check("start_one_cycle", prev_start, 0);
        check("start_from_idle", prev_busy, 0);
        check("start_slot_free", prev_slot_free, 1);
        if (pq.size() == 0) begin
          check("start_unexpected", 1, 0);
        end else begin
          p = pq.pop_front();
          check("issue_x", core_x, p.x);
          check("issue_y", core_y, p.y);
          rq.push_back(p.x + p.y);
        end
      end
      check("fill", fill, m_fill);
      check("in_ready", in_ready, (m_fill != DEPTH));
      if (fill == DEPTH && !in_ready) saw_full = 1'b1;
`ifdef COS_SEQ_TIMEOUT_EN
      if (err && !prev_err && !prev_rst && rq.size() > 0) void'(rq.pop_back());
`endif
      if (!rst && out_valid && out_ready) begin
        if (rq.size() == 0) begin
          check("result_unexpected", out_w, 32'hFFFF_FFFF);
        end else begin
          check("result", out_w, rq.pop_front());
        end
        got.push_back(out_w);
      end
      if (!rst && in_valid && in_ready) begin
        p.x = in_x;
        p.y = in_y;
        pq.push_back(p);
        m_fill++;
      end
      if (rst) begin
        pq.delete();
        rq.delete();
        m_fill = 0;
      end
      prev_rst       = rst;
      prev_start     = core_start;
      prev_busy      = busy;
      prev_slot_free = !out_valid || out_ready;
      prev_hold      = out_valid && !out_ready && !rst;
      prev_err       = err;
      prev_cx        = core_x;
      prev_cy        = core_y;
      prev_outw      = out_w;
    end
  end

  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    check("push_accepted", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string nm);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(nm, (got.size() >= n), 1);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, g0, k;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1; stub_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single transaction with literal timing and value.
    push(16'h010B, 16'h0066);
    @(negedge clk); check("t1_start_lat1", core_start, 0);
    @(negedge clk); check("t1_start_lat2", core_start, 1);
    check("t1_core_x", core_x, 16'h010B);
    check("t1_core_y", core_y, 16'h0066);
    k = 0;
    while (!out_valid && k < 30) begin @(negedge clk); k++; end
    check("t1_out_valid", out_valid, 1);
    check("t1_out_w", out_w, 16'h0171);
    @(negedge clk); check("t1_out_valid_1cyc", out_valid, 0);
    repeat (5) @(negedge clk);
    check("t1_one_start", n_start, 1);

    // Five back-to-back pushes against a busy core.
    @(posedge clk); #1;
    got.delete(); saw_full = 1'b0;
    for (int i = 0; i < 5; i++) push(16'h010B + 16'(i), 16'h000A * 16'(i + 1));
    wait_got(5, 600, "t2_all_results");
    check("t2_saw_full", saw_full, 1);
    if (got.size() >= 5) begin
      check("t2_first", got[0], 16'h0115);
      check("t2_last",  got[4], 16'h0141);
    end

    // Downstream stall with two results pending.
    @(posedge clk); #1;
    out_ready = 1'b0;
    s0 = n_start; g0 = got.size();
    push(16'h0001, 16'h0002);
    push(16'h0010, 16'h0020);
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    check("t3_out_valid", out_valid, 1);
    repeat (20) @(negedge clk);
    check("t3_second_withheld", n_start, s0 + 1);
    check("t3_out_w_held", out_w, 16'h0003);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_got(g0 + 2, 60, "t3_both_results");
    if (got.size() >= g0 + 2) begin
      check("t3_res0", got[g0], 16'h0003);
      check("t3_res1", got[g0 + 1], 16'h0030);
    end
    check("t3_starts", n_start, s0 + 2);

`ifdef COS_SEQ_TIMEOUT_EN
    // Core never drops Ready: timeout, no output, next pair still issues.
    @(posedge clk); #1;
    stub_hold = 1'b1;
    s0 = n_start; g0 = got.size();
    push(16'h0100, 16'h0200);
    push(16'h0005, 16'h0006);
    k = 0;
    while (n_start == s0 && k < 20) begin @(negedge clk); k++; end
    check("t4_first_start", n_start, s0 + 1);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      check("t4_err_early", err, 0);
      check("t4_busy", busy, 1);
    end
    @(negedge clk);
    check("t4_err_set", err, 1);
    check("t4_idle", busy, 0);
    check("t4_no_output", out_valid, 0);
    @(posedge clk); #1 stub_hold = 1'b0;
    wait_got(g0 + 1, 60, "t4_next_result");
    if (got.size() >= g0 + 1) check("t4_next_value", got[g0], 16'h000B);
    check("t4_starts", n_start, s0 + 2);
`endif

    // Reset in WAIT_DONE with two pairs queued.
    @(posedge clk); #1;
    s0 = n_start;
    push(16'h0111, 16'h0222);
    push(16'h0333, 16'h0444);
    push(16'h0555, 16'h0666);
    k = 0;
    while (n_start == s0 && k < 20) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    check("t5_busy_before", busy, 1);
    check("t5_fill_before", fill, 2);
    check("t5_core_low", core_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    s0 = n_start; g0 = got.size();
    repeat (20) @(negedge clk);
    check("t5_no_result", got.size(), g0);
    check("t5_no_start", n_start, s0);
    check("t5_fill_after", fill, 0);

    // Random traffic against the model.
    @(posedge clk); #1;
    for (int c = 0; c < 1500; c++) begin
      in_valid  = $urandom_range(0, 1);
      in_x      = W'($urandom);
      in_y      = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while ((pq.size() != 0 || rq.size() != 0 || busy || out_valid) && k < 1000) begin
      @(negedge clk); k++;
    end
    check("rand_drained_pairs", pq.size(), 0);
    check("rand_drained_results", rq.size(), 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
